datapath_ctrl: RTL and testbench

Control sequencer that drives the select/enable/mode inputs of the 8-bit add/subtract accumulator datapath. It accepts a short micro-program (initial load of A followed by up to four add/sub steps on B, C or D), steps the datapath through it one operation per clock, and reports completion with a one-cycle `done` pulse. It sits beside the datapath in the same clock domain; the datapath's `result` is valid when `done` is high.

---
 rtl/datapath_ctrl_pkg.sv | 57 +++++
 rtl/datapath_ctrl.sv | 102 ++++++++++
 tb/tb_datapath_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the accumulator datapath sequencer.
// Also holds the control-word decode helpers used by the FSM.
package datapath_ctrl_pkg;

    localparam int MAX_STEPS = 4;
    localparam int STEP_W    = 3;
    localparam int PROG_W    = MAX_STEPS * STEP_W;

    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;
    typedef enum logic [1:0] {OP_B, OP_C, OP_D, OP_SKIP} op_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef struct packed {
        logic s0;
        logic s2;
        logic s1;
        logic m;
        logic e;
        logic busy;
        logic done;
    } ctrl_t;

    function automatic ctrl_t ctrl_load();
        ctrl_t c;
        c      = '0;
        c.e    = 1'b1;
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_done();
        ctrl_t c;
        c      = '0;
        c.done = 1'b1;
        return c;
    endfunction

    // A skipped step keeps the accumulator but still counts as a busy cycle.
    function automatic ctrl_t ctrl_step(logic [STEP_W-1:0] w);
        ctrl_t c;
        c      = '0;
        c.s0   = 1'b1;
        c.busy = 1'b1;
        if (op_t'(w[2:1]) != OP_SKIP) begin
            c.s2 = w[2];
            c.s1 = w[1];
            c.m  = (w[0] == SUB) ? SUB : ADD;
            c.e  = 1'b1;
        end else begin
            c.m  = ADD;
        end
        return c;
    endfunction

endpackage

// File: rtl/datapath_ctrl.sv
// Micro-program sequencer for the add/sub accumulator datapath: LOAD A, then
// up to four add/sub/skip steps, then a one-cycle done pulse.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROG_W-1:0] prog,
    input  logic [2:0]        len,
    output logic              s0,
    output logic              s1,
    output logic              s2,
    output logic              m,
    output logic              e,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [1:0]        r_k;
    logic [PROG_W-1:0] r_prog;
    logic [2:0]        r_len;
    ctrl_t             r_ctrl;

    logic [1:0]        w_k_next;
    logic              w_last;
    logic [2:0]        w_len_clamped;

    assign w_k_next      = r_k + 2'd1;
    assign w_last        = ({1'b0, r_k} == (r_len - 3'd1));
    assign w_len_clamped = (len > 3'd4) ? 3'd4 : len;

    function automatic logic [STEP_W-1:0] step_word(logic [PROG_W-1:0] p, logic [1:0] k);
        case (k)
            2'd0:    return p[2:0];
            2'd1:    return p[5:3];
            2'd2:    return p[8:6];
            default: return p[11:9];
        endcase
    endfunction

    // Outputs are registered: each transition loads the control word of the
    // state being entered, so nothing combinational reaches the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_prog  <= '0;
            r_len   <= '0;
            r_ctrl  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ctrl <= '0;
                    if (start) begin
                        r_prog  <= prog;
                        r_len   <= w_len_clamped;
                        r_state <= LOAD;
                        r_ctrl  <= ctrl_load();
                    end
                end
                LOAD: begin
                    r_k <= '0;
                    if (r_len != 3'd0) begin
                        r_state <= STEP;
                        r_ctrl  <= ctrl_step(step_word(r_prog, 2'd0));
                    end else begin
                        r_state <= DONE;
                        r_ctrl  <= ctrl_done();
                    end
                end
                STEP: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_ctrl  <= ctrl_done();
                    end else begin
                        r_k    <= w_k_next;
                        r_ctrl <= ctrl_step(step_word(r_prog, w_k_next));
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ctrl  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    assign s0   = r_ctrl.s0;
    assign s1   = r_ctrl.s1;
    assign s2   = r_ctrl.s2;
    assign m    = r_ctrl.m;
    assign e    = r_ctrl.e;
    assign busy = r_ctrl.busy;
    assign done = r_ctrl.done;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a small accumulator driven by the controller,
// a sequence-level model of the expected control outputs, directed cases.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] prog;
    logic [2:0]  len;
    logic        s0, s1, s2, m, e, busy, done;

    logic [7:0]  a_v, b_v, c_v, d_v, acc;

    int n_chk  = 0;
    int n_fail = 0;

    datapath_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .prog(prog), .len(len),
        .s0(s0), .s1(s1), .s2(s2), .m(m), .e(e), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Accumulator standing in for the datapath, steered only by the controller.
    always @(posedge clk) begin
        if (e) begin
            if (!s0)
                acc <= a_v;
            else begin
                logic [7:0] opnd;
                case ({s2, s1})
                    2'b00:   opnd = b_v;
                    2'b01:   opnd = c_v;
                    2'b10:   opnd = d_v;
                    default: opnd = 8'h00;
                endcase
                acc <= m ? acc - opnd : acc + opnd;
            end
        end
    end

    // Model: on an accepted start, lay out the whole output sequence at once.
    // Vector order {s0,s2,s1,m,e,busy,done}.
    logic [6:0] cur_exp = '0;
    logic [6:0] exp_q[$];
    logic [7:0] exp_res;
    bit         started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            exp_q.delete();
            cur_exp = '0;
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end else if (cur_exp == 7'b0 && start) begin
            int         nst;
            logic [7:0] res;
            nst = (len > 3'd4) ? 4 : int'(len);
            res = a_v;
            cur_exp = 7'b0000110;
            for (int k = 0; k < nst; k++) begin
                logic [2:0] w;
                w = prog[3*k +: 3];
                case (w[2:1])
                    2'b00: res = w[0] ? res - b_v : res + b_v;
                    2'b01: res = w[0] ? res - c_v : res + c_v;
                    2'b10: res = w[0] ? res - d_v : res + d_v;
                    default: ;
                endcase
                if (w[2:1] == 2'b11) exp_q.push_back(7'b1000010);
                else                 exp_q.push_back({1'b1, w[2:1], w[0], 1'b1, 1'b1, 1'b0});
            end
            exp_q.push_back(7'b0000001);
            exp_res = res;
        end else begin
            cur_exp = '0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            n_chk++;
            if ({s0, s2, s1, m, e, busy, done} !== cur_exp) begin
                n_fail++;
                $display("FAIL ctrl_outputs t=%0t got=%b want=%b", $time,
                         {s0, s2, s1, m, e, busy, done}, cur_exp);
            end
            if (cur_exp[0]) begin
                n_chk++;
                if (acc !== exp_res) begin
                    n_fail++;
                    $display("FAIL model_result t=%0t got=%0d want=%0d", $time, acc, exp_res);
                end
            end
        end
    end

    task automatic check(string name, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Pulse start in cycle t; returns result at done, latency and e per cycle.
    task automatic run(input logic [7:0] a, b, c, d, input logic [11:0] p,
                       input logic [2:0] l, input string name,
                       input int want_res, input int want_lat, output logic [7:0] etr);
        int cyc;
        etr = '0;
        @(posedge clk); #1;
        a_v = a; b_v = b; c_v = c; d_v = d; prog = p; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (1) begin
            @(negedge clk);
            etr[cyc] = e;
            if (done) break;
            if (cyc >= 10) begin
                n_chk++; n_fail++;
                $display("FAIL %s_timeout got=no_done want=done", name);
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, want_lat);
        check({name, "_result"}, int'(acc), want_res);
    endtask

    initial begin
        logic [7:0] etr;
        int         ndone, res_at_done;
        reset = 1'b1; start = 1'b0; prog = '0; len = '0;
        a_v = 0; b_v = 0; c_v = 0; d_v = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({s0, s1, s2, m, e, busy, done}), 0);
        reset = 1'b0;

        run(10, 3, 5, 1, {3'b110, 3'b100, 3'b011, 3'b000}, 3, "mixed", 9, 5, etr);
        run(250, 10, 0, 0, 12'b000, 1, "wrap", 4, 3, etr);
        run(77, 0, 0, 0, 12'hfff, 0, "len0", 77, 2, etr);
        run(0, 1, 0, 0, 12'b0, 7, "clamp", 4, 6, etr);
        run(20, 2, 0, 5, {3'b000, 3'b101, 3'b110, 3'b000}, 3, "skip", 17, 5, etr);
        check("skip_e_trace", int'(etr[4:1]), 4'b1011);

        // Restart attempt and program change while busy must be ignored.
        @(posedge clk); #1;
        a_v = 10; b_v = 3; c_v = 5; d_v = 1;
        prog = {3'b110, 3'b100, 3'b011, 3'b000}; len = 3; start = 1'b1;
        ndone = 0; res_at_done = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin prog = 12'b0; len = 4; end
            if (i == 3) start = 1'b0;
            @(negedge clk);
            if (done) begin ndone++; res_at_done = int'(acc); end
        end
        check("busy_ignore_done_count", ndone, 1);
        check("busy_ignore_result", res_at_done, 9);

        // Reset during the second step.
        @(posedge clk); #1;
        a_v = 10; b_v = 3; c_v = 5; d_v = 1;
        prog = {3'b110, 3'b100, 3'b011, 3'b000}; len = 3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", int'({s0, s1, s2, m, e, busy, done}), 0);
        reset = 1'b0;
        run(10, 3, 5, 1, {3'b110, 3'b100, 3'b011, 3'b000}, 3, "after_reset", 9, 5, etr);

        // Randomized traffic; operands fixed so the model's result stays valid.
        @(posedge clk); #1;
        a_v = 8'($urandom); b_v = 8'($urandom); c_v = 8'($urandom); d_v = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            prog  = 12'($urandom);
            len   = 3'($urandom);
            reset = ($urandom_range(0, 60) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
